clock_inputs: RTL and testbench

Upstream front end for `clock_control`: converts the Mimas V2 raw push buttons and the 100 MHz board clock into that block's control inputs. It generates the 1 s tick and the fast edit tick, and debounces four buttons. It also maintains the edit-mode toggle and the field-select counter. All outputs are registered and connect directly to `clock_control`'s `i_pulse_n`, `i_pulse_f`, `i_inc_pulse`, `i_dec_pulse`, `i_wr` and `i_sel`.

---
 rtl/clock_inputs_pkg.sv | 21 ++
 rtl/btn_debounce.sv | 59 +++++
 rtl/clock_inputs.sv | 104 ++++++++++
 tb/tb_clock_inputs.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_inputs_pkg.sv
// Shared constants for the clock front end: default timing parameters,
// field-select encodings used by the downstream demux, and a width helper.
package clock_inputs_pkg;

  localparam int CLK_HZ_DEFAULT    = 100_000_000;
  localparam int FAST_DIV_DEFAULT  = 12_500_000;
  localparam int DB_CYCLES_DEFAULT = 1_000_000;

  typedef enum logic [1:0] {
    SEL_SS = 2'd0,
    SEL_MM = 2'd1,
    SEL_HH = 2'd2,
    SEL_PM = 2'd3
  } sel_e;

  // Counter width for a modulus n, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button path: 2-flop synchroniser, active-low to active-high
// inversion, stability counter and a one-cycle press strobe. The next
// accepted state is exported so the parent can register its outputs on
// the same edge on which the accepted state flips.
module btn_debounce
  import clock_inputs_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic state_next,
  output logic press
);

  localparam int CW = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          meta;
  logic          sync;
  logic          state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          level;

  assign level = ~sync;

  // Synchronise the raw button and hold the accepted state and its counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta  <= 1'b1;
      sync  <= 1'b1;
      state <= 1'b0;
      cnt   <= '0;
    end else begin
      meta  <= btn_n;
      sync  <= meta;
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Count cycles of disagreement; flip on the last one, strobe on a press.
  always_comb begin
    state_next = state;
    cnt_next   = '0;
    press      = 1'b0;
    if (level != state) begin
      if (cnt == CNT_LAST) begin
        state_next = level;
        press      = level;
      end else begin
        cnt_next = cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_inputs.sv
// Front end for clock_control: 1 s and fast edit tick dividers, four
// debounced buttons, the edit-mode toggle and the field-select counter.
// Every output is registered; they are all computed from the same-cycle
// next-state values so that press, mode and select land on one edge.
module clock_inputs
  import clock_inputs_pkg::*;
#(
  parameter int CLK_HZ    = CLK_HZ_DEFAULT,
  parameter int FAST_DIV  = FAST_DIV_DEFAULT,
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_btn_inc_n,
  input  logic       i_btn_dec_n,
  input  logic       i_btn_mode_n,
  input  logic       i_btn_sel_n,
  output logic       o_pulse_n,
  output logic       o_pulse_f,
  output logic       o_inc_pulse,
  output logic       o_dec_pulse,
  output logic       o_wr,
  output logic [1:0] o_sel
);

  localparam int SW = cnt_width(CLK_HZ);
  localparam int FW = cnt_width(FAST_DIV);
  localparam logic [SW-1:0] SLOW_LAST = SW'(CLK_HZ - 1);
  localparam logic [FW-1:0] FAST_LAST = FW'(FAST_DIV - 1);

  logic inc_state, dec_state, mode_state, sel_state;
  logic inc_press, dec_press, mode_press, sel_press;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_inc (
    .clk(i_clk), .reset(i_reset), .btn_n(i_btn_inc_n),
    .state_next(inc_state), .press(inc_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dec (
    .clk(i_clk), .reset(i_reset), .btn_n(i_btn_dec_n),
    .state_next(dec_state), .press(dec_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
    .clk(i_clk), .reset(i_reset), .btn_n(i_btn_mode_n),
    .state_next(mode_state), .press(mode_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_sel (
    .clk(i_clk), .reset(i_reset), .btn_n(i_btn_sel_n),
    .state_next(sel_state), .press(sel_press)
  );

  // Inc/dec only act as levels and mode/sel only as strobes.
  logic unused_btn;
  assign unused_btn = inc_press ^ dec_press ^ mode_state ^ sel_state;

  logic [SW-1:0] slow_cnt;
  logic [SW-1:0] slow_next;
  logic [FW-1:0] fast_cnt;
  logic [FW-1:0] fast_next;
  logic          wr_next;
  logic          wr_rise;
  logic          wr_fall;

  // Edit-mode transition detection and divider next values.
  always_comb begin
    wr_next = o_wr ^ mode_press;
    wr_rise = ~o_wr & wr_next;
    wr_fall = o_wr & ~wr_next;

    if (wr_fall || slow_cnt == SLOW_LAST) slow_next = '0;
    else                                   slow_next = slow_cnt + 1'b1;

    if (wr_rise || fast_cnt == FAST_LAST) fast_next = '0;
    else                                   fast_next = fast_cnt + 1'b1;
  end

  // Dividers, edit mode, field select and the gated inc/dec levels.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      slow_cnt    <= '0;
      fast_cnt    <= '0;
      o_pulse_n   <= 1'b0;
      o_pulse_f   <= 1'b0;
      o_wr        <= 1'b0;
      o_sel       <= SEL_SS;
      o_inc_pulse <= 1'b0;
      o_dec_pulse <= 1'b0;
    end else begin
      slow_cnt    <= slow_next;
      fast_cnt    <= fast_next;
      o_pulse_n   <= (slow_next == SLOW_LAST);
      o_pulse_f   <= (fast_next == FAST_LAST);
      o_wr        <= wr_next;
      // Select advances on the pre-update mode, so a simultaneous mode
      // press entering edit mode does not also move the field.
      if (sel_press && o_wr) o_sel <= o_sel + 2'd1;
      o_inc_pulse <= inc_state & wr_next;
      o_dec_pulse <= dec_state & ~inc_state & wr_next;
    end
  end

endmodule

// File: tb/tb_clock_inputs.sv
// Bench for clock_inputs with CLK_HZ=20, FAST_DIV=4, DB_CYCLES=3.
// Expected values are queued with the cycle they are due and compared
// on the falling edge of that cycle.
module tb_clock_inputs;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_inc_n, btn_dec_n, btn_mode_n, btn_sel_n;
  logic       pulse_n, pulse_f, inc_pulse, dec_pulse, wr;
  logic [1:0] sel;

  clock_inputs #(.CLK_HZ(20), .FAST_DIV(4), .DB_CYCLES(3)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_btn_inc_n(btn_inc_n), .i_btn_dec_n(btn_dec_n),
    .i_btn_mode_n(btn_mode_n), .i_btn_sel_n(btn_sel_n),
    .o_pulse_n(pulse_n), .o_pulse_f(pulse_f),
    .o_inc_pulse(inc_pulse), .o_dec_pulse(dec_pulse),
    .o_wr(wr), .o_sel(sel)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int S_PN = 0, S_PF = 1, S_INC = 2, S_DEC = 3, S_WR = 4, S_SEL = 5;

  typedef struct {
    int         due;
    int         sig;
    logic [1:0] exp;
    string      name;
  } sb_t;

  sb_t sb[$];
  int  tests = 0;
  int  fails = 0;

  typedef struct packed {
    logic       wr;
    logic [1:0] sel;
    logic       inc;
    logic       dec;
  } outs_t;

  typedef struct {
    string      name;
    logic [3:0] press;   // {inc, dec, mode, sel}
    outs_t      held;
    outs_t      rel;
    bit         chk_fast;
    bit         chk_slow;
  } vec_t;

  function automatic logic [1:0] get_sig(input int s);
    case (s)
      S_PN:    return {1'b0, pulse_n};
      S_PF:    return {1'b0, pulse_f};
      S_INC:   return {1'b0, inc_pulse};
      S_DEC:   return {1'b0, dec_pulse};
      S_WR:    return {1'b0, wr};
      default: return sel;
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        logic [1:0] act;
        act = get_sig(sb[i].sig);
        tests++;
        if (act !== sb[i].exp) begin
          fails++;
          $display("FAIL %s cyc=%0d got=%0d want=%0d", sb[i].name, cyc, act, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  task automatic expect_at(input int due, input int sig, input logic [1:0] exp, input string name);
    sb_t e;
    e.due = due; e.sig = sig; e.exp = exp; e.name = name;
    sb.push_back(e);
  endtask

  task automatic expect_outs(input int due, input outs_t o, input string tag);
    expect_at(due, S_WR,  {1'b0, o.wr},  {tag, "_wr"});
    expect_at(due, S_SEL, o.sel,         {tag, "_sel"});
    expect_at(due, S_INC, {1'b0, o.inc}, {tag, "_inc"});
    expect_at(due, S_DEC, {1'b0, o.dec}, {tag, "_dec"});
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_btn(input logic [3:0] mask);
    btn_inc_n  = ~mask[3];
    btn_dec_n  = ~mask[2];
    btn_mode_n = ~mask[1];
    btn_sel_n  = ~mask[0];
  endtask

  localparam int NV = 12;
  vec_t  vec [NV];
  outs_t prev;
  int    base, t;

  initial begin
    vec[0]  = '{"mode_on",     4'b0010, 5'b1_00_0_0, 5'b1_00_0_0, 1'b1, 1'b0};
    vec[1]  = '{"sel_1",       4'b0001, 5'b1_01_0_0, 5'b1_01_0_0, 1'b0, 1'b0};
    vec[2]  = '{"sel_2",       4'b0001, 5'b1_10_0_0, 5'b1_10_0_0, 1'b0, 1'b0};
    vec[3]  = '{"sel_3",       4'b0001, 5'b1_11_0_0, 5'b1_11_0_0, 1'b0, 1'b0};
    vec[4]  = '{"sel_wrap",    4'b0001, 5'b1_00_0_0, 5'b1_00_0_0, 1'b0, 1'b0};
    vec[5]  = '{"sel_5",       4'b0001, 5'b1_01_0_0, 5'b1_01_0_0, 1'b0, 1'b0};
    vec[6]  = '{"inc_dec",     4'b1100, 5'b1_01_1_0, 5'b1_01_0_0, 1'b0, 1'b0};
    vec[7]  = '{"mode_off",    4'b0010, 5'b0_01_0_0, 5'b0_01_0_0, 1'b0, 1'b1};
    vec[8]  = '{"sel_idle",    4'b0001, 5'b0_01_0_0, 5'b0_01_0_0, 1'b0, 1'b0};
    vec[9]  = '{"dec_idle",    4'b0100, 5'b0_01_0_0, 5'b0_01_0_0, 1'b0, 1'b0};
    vec[10] = '{"mode_and_sel",4'b0011, 5'b1_01_0_0, 5'b1_01_0_0, 1'b0, 1'b0};
    vec[11] = '{"dec_edit",    4'b0100, 5'b1_01_0_1, 5'b1_01_0_0, 1'b0, 1'b0};

    reset = 1'b1;
    drive_btn(4'b0000);
    wait_cycles(3);
    reset = 1'b0;
    base = cyc;

    tests++;
    if (wr !== 1'b0) begin
      fails++;
      $display("FAIL direct_rst_wr got=%0b", wr);
    end
    tests++;
    if (sel !== 2'b00) begin
      fails++;
      $display("FAIL direct_rst_sel got=%0d", sel);
    end
    tests++;
    if ({inc_pulse, dec_pulse} !== 2'b00) begin
      fails++;
      $display("FAIL direct_rst_incdec got=%0b%0b", inc_pulse, dec_pulse);
    end
    tests++;
    if ({pulse_n, pulse_f} !== 2'b00) begin
      fails++;
      $display("FAIL direct_rst_pulses got=%0b%0b", pulse_n, pulse_f);
    end

    // Reset state and free-running dividers.
    expect_outs(base, 5'b0, "rst");
    expect_at(base, S_PN, 2'd0, "rst_pn");
    expect_at(base, S_PF, 2'd0, "rst_pf");
    expect_at(base + 18, S_PN, 2'd0, "pn_18");
    expect_at(base + 19, S_PN, 2'd1, "pn_19");
    expect_at(base + 20, S_PN, 2'd0, "pn_20");
    expect_at(base + 39, S_PN, 2'd1, "pn_39");
    expect_at(base + 59, S_PN, 2'd1, "pn_59");
    expect_at(base + 2,  S_PF, 2'd0, "pf_2");
    expect_at(base + 3,  S_PF, 2'd1, "pf_3");
    expect_at(base + 4,  S_PF, 2'd0, "pf_4");
    expect_at(base + 7,  S_PF, 2'd1, "pf_7");
    expect_at(base + 11, S_PF, 2'd1, "pf_11");
    wait_cycles(62);

    // Two-cycle bounce on mode must not toggle edit mode.
    t = cyc;
    for (int k = 1; k <= 9; k++) expect_at(t + k, S_WR, 2'd0, "bounce_wr");
    drive_btn(4'b0010);
    wait_cycles(2);
    drive_btn(4'b0000);
    wait_cycles(10);

    // Table of clean presses: hold 7 cycles, release, settle 8 cycles.
    prev = 5'b0;
    for (int i = 0; i < NV; i++) begin
      t = cyc;
      expect_outs(t + 4,  prev,        {vec[i].name, "_pre"});
      expect_outs(t + 5,  vec[i].held, {vec[i].name, "_held"});
      expect_outs(t + 13, vec[i].rel,  {vec[i].name, "_rel"});
      if (vec[i].chk_fast) begin
        for (int k = 5; k <= 7; k++) expect_at(t + k, S_PF, 2'd0, "fast_restart_lo");
        expect_at(t + 8, S_PF, 2'd1, "fast_restart_hi");
      end
      if (vec[i].chk_slow) begin
        for (int k = 5; k <= 23; k++) expect_at(t + k, S_PN, 2'd0, "slow_restart_lo");
        expect_at(t + 24, S_PN, 2'd1, "slow_restart_hi");
      end
      drive_btn(vec[i].press);
      wait_cycles(7);
      drive_btn(4'b0000);
      wait_cycles(8);
      prev = vec[i].rel;
    end

    // Hold inc+dec in edit mode, then release inc: dec takes over.
    t = cyc;
    expect_at(t + 5,  S_INC, 2'd1, "both_inc");
    expect_at(t + 5,  S_DEC, 2'd0, "both_dec");
    expect_at(t + 12, S_DEC, 2'd0, "inc_rel_dec_early");
    expect_at(t + 12, S_INC, 2'd1, "inc_rel_inc_early");
    expect_at(t + 13, S_DEC, 2'd1, "inc_rel_dec");
    expect_at(t + 13, S_INC, 2'd0, "inc_rel_inc");
    drive_btn(4'b1100);
    wait_cycles(8);
    drive_btn(4'b0100);
    wait_cycles(8);
    drive_btn(4'b0000);
    wait_cycles(8);

    // Reset during a partial mode debounce and mid-divider.
    t = cyc;
    expect_outs(t + 4, 5'b0, "mid_rst");
    expect_at(t + 4,  S_PN, 2'd0, "mid_rst_pn");
    expect_at(t + 4,  S_PF, 2'd0, "mid_rst_pf");
    expect_at(t + 5,  S_PN, 2'd0, "mid_rst_pn_next");
    expect_at(t + 8,  S_WR, 2'd0, "fresh_wr_early");
    expect_at(t + 9,  S_WR, 2'd1, "fresh_wr");
    expect_at(t + 22, S_PN, 2'd0, "mid_rst_pn_18");
    expect_at(t + 23, S_PN, 2'd1, "mid_rst_pn_19");
    drive_btn(4'b0010);
    wait_cycles(3);
    reset = 1'b1;
    wait_cycles(1);
    reset = 1'b0;
    wait_cycles(8);
    drive_btn(4'b0000);
    wait_cycles(20);

    tests++;
    if (wr !== 1'b1) begin
      fails++;
      $display("FAIL direct_end_wr got=%0b", wr);
    end
    tests++;
    if (sel !== 2'b00) begin
      fails++;
      $display("FAIL direct_end_sel got=%0d", sel);
    end
    tests++;
    if ({inc_pulse, dec_pulse} !== 2'b00) begin
      fails++;
      $display("FAIL direct_end_incdec got=%0b%0b", inc_pulse, dec_pulse);
    end

    while (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL %s never sampled (due %0d, now %0d)", sb[0].name, sb[0].due, cyc);
      sb.delete(0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
